// File: rtl/tatsujin_pkg.sv
// rtl/tatsujin_pkg.sv - shared colours, screen geometry and FSM states for the note row drawer
// Contents: colour constants, default slot count, screen height, slot index width,
//           scheduler state enum, note colour priority helper.
package tatsujin_pkg;

  localparam logic [2:0] COLOUR_RED    = 3'b100;
  localparam logic [2:0] COLOUR_YELLOW = 3'b110;
  localparam logic [2:0] COLOUR_BLACK  = 3'b000;

  localparam int SLOT_COUNT_DEF = 10;
  localparam int SCREEN_H       = 120;
  localparam int SLOT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_FINISH
  } state_t;

  // Red has priority over yellow; an empty slot is painted black to erase it.
  function automatic logic [2:0] note_colour(input logic red, input logic yellow);
    if (red)         return COLOUR_RED;
    else if (yellow) return COLOUR_YELLOW;
    else             return COLOUR_BLACK;
  endfunction

endpackage

// File: rtl/note_row_scheduler_if.sv
// rtl/note_row_scheduler_if.sv - request and pixel bus of the note row scheduler
// Signals: go, red_seq[9:0], yellow_seq[9:0], base_x[7:0], base_y[6:0] (requester -> scheduler);
//          x[7:0], y[6:0], colour[2:0], plot, busy, done (scheduler -> VGA adapter / requester).
// Modports: master = requester side, slave = scheduler side.
interface note_row_scheduler_if;
  logic       go;
  logic [9:0] red_seq;
  logic [9:0] yellow_seq;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output go, red_seq, yellow_seq, base_x, base_y,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  go, red_seq, yellow_seq, base_x, base_y,
    output x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/square_offset_counter.sv
// rtl/square_offset_counter.sv - 4-bit pixel counter walking a 4x4 square in raster order
// Ports: clk, resetn (async, active-low), clr (load 0), en (advance),
//        wrap (current count is 15), xoff_next/yoff_next (offsets of the count being loaded).
module square_offset_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic       wrap,
  output logic [1:0] xoff_next,
  output logic [1:0] yoff_next
);

  logic [3:0] p;
  logic [3:0] p_d;

  // 15 + 1 wraps to 0 naturally, starting the next slot's square.
  always_comb begin
    p_d = p;
    if (clr)     p_d = 4'd0;
    else if (en) p_d = p + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) p <= 4'd0;
    else         p <= p_d;
  end

  assign wrap      = (p == 4'd15);
  // The parent registers its pixel outputs, so it needs the offsets of the next count.
  assign xoff_next = p_d[1:0];
  assign yoff_next = p_d[3:2];

endmodule

// File: rtl/note_row_scheduler.sv
// rtl/note_row_scheduler.sv - draws a row of 4x4 note squares, one pixel per clock, to a VGA adapter
// Ports: clk, resetn (async, active-low), bus (note_row_scheduler_if.slave):
//        go starts a pass from IDLE; red_seq/yellow_seq/base_x/base_y are latched at start;
//        x/y/colour/plot are registered pixel outputs; busy covers DRAW+FINISH; done pulses in FINISH.
module note_row_scheduler
  import tatsujin_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int SLOT_PITCH = 8,
  parameter int SCREEN_W   = 160
) (
  input  logic                 clk,
  input  logic                 resetn,
  note_row_scheduler_if.slave  bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_COUNT - 1);

  state_t            state, state_d;
  logic [SLOT_W-1:0] slot, slot_d;
  logic [9:0]        red_q, red_d;
  logic [9:0]        yellow_q, yellow_d;
  logic [7:0]        bx_q, bx_d;
  logic [6:0]        by_q, by_d;

  logic              start;
  logic              cnt_en;
  logic              wrap;
  logic [1:0]        xoff_n, yoff_n;

  logic [11:0]       x_sum;
  logic [7:0]        y_sum;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        colour_q, colour_d;
  logic              plot_q, plot_d;

  square_offset_counter u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (start),
    .en        (cnt_en),
    .wrap      (wrap),
    .xoff_next (xoff_n),
    .yoff_next (yoff_n)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d  = state;
    slot_d   = slot;
    red_d    = red_q;
    yellow_d = yellow_q;
    bx_d     = bx_q;
    by_d     = by_q;
    start    = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.go) begin
          start    = 1'b1;
          state_d  = ST_DRAW;
          slot_d   = '0;
          red_d    = bus.red_seq;
          yellow_d = bus.yellow_seq;
          bx_d     = bus.base_x;
          by_d     = bus.base_y;
        end
      end
      ST_DRAW: begin
        cnt_en = 1'b1;
        if (wrap) begin
          if (slot == LAST_SLOT) state_d = ST_FINISH;
          else                   slot_d  = slot + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Pixel outputs are computed from next-cycle values so they register in step with the state.
    x_sum    = {4'b0, bx_d} + 12'(slot_d) * 12'(SLOT_PITCH) + {10'b0, xoff_n};
    y_sum    = {1'b0, by_d} + {6'b0, yoff_n};
    plot_d   = (state_d == ST_DRAW) && (x_sum < 12'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
    colour_d = note_colour(red_d[slot_d], yellow_d[slot_d]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot     <= '0;
      red_q    <= '0;
      yellow_q <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      slot     <= slot_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      plot_q   <= plot_d;
      if (state_d == ST_DRAW) begin
        x_q      <= x_sum[7:0];
        y_q      <= y_sum[6:0];
        colour_q <= colour_d;
      end
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = (state == ST_FINISH);

endmodule

// File: tb/tb_note_row_scheduler.sv
// tb/tb_note_row_scheduler.sv - self-checking bench for note_row_scheduler
module tb_note_row_scheduler;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  note_row_scheduler_if bus();

  note_row_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel k of a pass: slot k/16, square position k%16 in raster order.
  function automatic void exp_pixel(input int k, input logic [9:0] r, input logic [9:0] yl,
                                    input int bx, input int by,
                                    output int ex, output int ey, output int ec, output int ep);
    int slot, p, xs, ys;
    slot = k / 16;
    p    = k % 16;
    xs   = bx + slot * 8 + (p % 4);
    ys   = by + (p / 4);
    ex   = xs % 256;
    ey   = ys % 128;
    ec   = r[slot] ? 4 : (yl[slot] ? 6 : 0);
    ep   = (xs < 160 && ys < 120) ? 1 : 0;
  endfunction

  task automatic scramble();
    bus.red_seq    = 10'($urandom);
    bus.yellow_seq = 10'($urandom);
    bus.base_x     = 8'($urandom);
    bus.base_y     = 7'($urandom);
  endtask

  // Called at a negedge; starts a pass and checks all 160 pixels, FINISH and return to IDLE.
  task automatic run_pass(input logic [9:0] r, input logic [9:0] yl,
                          input logic [7:0] bx, input logic [6:0] by, input bit hold);
    int ex, ey, ec, ep, nplot, eplot;
    bus.red_seq    = r;
    bus.yellow_seq = yl;
    bus.base_x     = bx;
    bus.base_y     = by;
    bus.go         = 1'b1;
    @(posedge clk);
    nplot = 0;
    eplot = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      exp_pixel(k, r, yl, int'(bx), int'(by), ex, ey, ec, ep);
      chk("busy_draw", 32'(bus.busy), 32'd1);
      chk("done_draw", 32'(bus.done), 32'd0);
      chk("x", 32'(bus.x), 32'(ex));
      chk("y", 32'(bus.y), 32'(ey));
      chk("colour", 32'(bus.colour), 32'(ec));
      chk("plot", 32'(bus.plot), 32'(ep));
      nplot += int'(bus.plot);
      eplot += ep;
      scramble();
      if (!hold) bus.go = (k < 159) ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    chk("done_finish", 32'(bus.done), 32'd1);
    chk("busy_finish", 32'(bus.busy), 32'd1);
    chk("plot_finish", 32'(bus.plot), 32'd0);
    chk("plot_count", 32'(nplot), 32'(eplot));
    @(negedge clk);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("done_idle", 32'(bus.done), 32'd0);
    chk("plot_idle", 32'(bus.plot), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_x"}, 32'(bus.x), 32'd0);
    chk({tag, "_y"}, 32'(bus.y), 32'd0);
    chk({tag, "_colour"}, 32'(bus.colour), 32'd0);
    chk({tag, "_plot"}, 32'(bus.plot), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  task automatic reset_mid_pass();
    bus.red_seq    = 10'h3ff;
    bus.yellow_seq = 10'h000;
    bus.base_x     = 8'd10;
    bus.base_y     = 7'd10;
    bus.go         = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.go = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(bus.done), 32'd0);
      chk("rst_no_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bus.go         = 1'b0;
    bus.red_seq    = '0;
    bus.yellow_seq = '0;
    bus.base_x     = '0;
    bus.base_y     = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    resetn = 1'b1;
    @(negedge clk);
    check_reset_state("post_reset");

    run_pass(10'b0110101010, 10'b0000000000, 8'd20, 7'd50, 1'b0);
    run_pass(10'b0000000001, 10'b0000000011, 8'd0, 7'd0, 1'b0);
    run_pass(10'($urandom), 10'($urandom), 8'd150, 7'd10, 1'b0);
    run_pass(10'($urandom), 10'($urandom), 8'd30, 7'd20, 1'b1);
    run_pass(10'($urandom), 10'($urandom), 8'd40, 7'd30, 1'b0);
    reset_mid_pass();
    run_pass(10'($urandom), 10'($urandom), 8'd5, 7'd100, 1'b0);
    run_pass(10'($urandom), 10'($urandom), 8'd100, 7'd117, 1'b0);
    for (int i = 0; i < 6; i++)
      run_pass(10'($urandom), 10'($urandom), 8'($urandom), 7'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
